spi_slave_regfile: RTL and testbench
====================================

// Module: spi_slave_regfile
// PURPOSE
// - SPI mode-0 target (responder) for the HPS spim0 master: byte-framed command protocol onto a bank of 8-bit control registers.
// - Sits in the FPGA fabric of the peripheral system; the HPS configures fabric logic (LED/HDMI options) through it.
// - All SPI pins are oversampled in the single system clock; there is no SCLK clock domain.
// PARAMETERS
// - NUM_REGS     16     number of 8-bit registers, 1..128
// - RESET_VAL    8'h00  reset value of every register
// - SYNC_STAGES  2      synchronizer depth on sclk/mosi/ss_n, >=2
// PORTS
// - clk           in   1             system clock; SCLK must be <= clk/8
// - reset_n       in   1             asynchronous active-low reset
// - spi_sclk      in   1             SPI clock from master, idle low (CPOL=0)
// - spi_mosi      in   1             master-out data, sampled on SCLK rising edge
// - spi_ss_n      in   1             active-low select
// - spi_miso      out  1             target-out data, updated on SCLK falling edge
// - spi_miso_oe   out  1             1 = drive miso; equals synchronized select active
// - reg_q         out  NUM_REGS*8    register contents, reg n at [8n+7:8n]
// - wr_strobe     out  1             one-cycle pulse per committed register write
// - wr_addr       out  7             address of committed write
// - wr_data       out  8             data of committed write
// BEHAVIOUR
// - Reset: reg_q = all RESET_VAL, spi_miso=0, spi_miso_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, FSM=IDLE.
// - Inputs pass SYNC_STAGES flops; rise/fall of synced sclk detected by one extra flop (one-cycle edge pulses).
// - Frame: byte0 = {rnw, addr[6:0]}, MSB first; bytes 1..N = data; addr auto-increments per data byte, 7-bit wrap 127->0.
// - FSM IDLE: ss active -> CMD, bit_cnt=0, shift reg cleared. miso=0.
// - CMD: each rise shifts mosi in; on 8th rise latch rnw/addr, -> DATA; if rnw, load tx_shift with reg[addr] (0x00 if addr>=NUM_REGS).
// - DATA: rise shifts mosi into rx; fall presents tx_shift[7] on miso then shifts left.
//   8th rise of a byte: write (rnw=0) -> reg[addr]<=rx next cycle, wr_strobe=1 for that cycle with wr_addr/wr_data; addr>=NUM_REGS: no write, no strobe.
//   read (rnw=1): addr++, tx_shift reloaded from new addr so next byte follows on next fall.
// - miso during CMD byte and write frames: 0. First data bit driven on the fall after the 8th rise.
// - Latency: rise on pin -> internal edge pulse SYNC_STAGES+1 clk; miso valid SYNC_STAGES+2 clk after pin fall.
// - ss deassert (synced high) at any time: -> IDLE next cycle, partial byte discarded, no write; oe drops same cycle as synced ss.
// - Edge and synced ss-high in same cycle: edge ignored.
// - Write commit and readback of same register in a later byte: new value returned.
// - reset_n asserted mid-frame: immediate return to reset state; frame lost; master must reselect.
// - Writes only through SPI; reg_q changes only on a wr_strobe cycle.
// STRUCTURE
// - Package spi_slave_pkg: state enum {IDLE,CMD,DATA}, RNW_BIT=7, ADDR_W=7, BYTE_W=8.
// - Sub-module spi_sync_edge: SYNC_STAGES synchronizer + rise/fall pulse generator, instantiated for sclk; mosi/ss_n use sync-only output.
// - Top holds FSM, bit counter, rx/tx shift registers, address counter, register array.
// TESTING
// - Reset: reset_n low, NUM_REGS=16 -> reg_q all 0x00, miso_oe=0, wr_strobe never pulses.
// - Write: frame 0x05,0xA5 at clk/8 -> one wr_strobe, wr_addr=5, wr_data=0xA5, reg_q[47:40]=0xA5.
// - Burst read: regs 3,4 = 0x11,0x22; frame 0x83,xx,xx -> master samples 0x11 then 0x22; miso=0 during byte0.
// - Out-of-range: write 0x20,0x55 then read 0xA0,xx -> no strobe, read returns 0x00.
// - Abort: ss_n high after 5 bits of data byte following 0x02 -> no write, reg2 unchanged, next frame 0x02,0x3C works.
// - Wrap/reset: burst write from 0x7F with NUM_REGS=128, data 0x01,0x02 -> reg127=0x01, reg0=0x02; reset_n pulsed mid-byte -> all regs 0x00, miso_oe=0.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI mode-0 register-file target.
// Contents:
//   state_e  - frame FSM states (IDLE, CMD, DATA)
//   RNW_BIT  - position of the read/not-write flag in the command byte
//   ADDR_W   - register address width
//   BYTE_W   - SPI byte width
package spi_slave_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      DATA
   } state_e;

   localparam int unsigned RNW_BIT = 7;
   localparam int unsigned ADDR_W  = 7;
   localparam int unsigned BYTE_W  = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-bit input synchronizer with rise/fall pulse detection on bit 0.
// Bit 0 carries the SPI clock; the other bits are only synchronized.
// Ports:
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset
//   d_i     - asynchronous inputs
//   sync_o  - inputs after STAGES flops
//   rise_o  - one-cycle pulse on a 0->1 transition of sync_o[0]
//   fall_o  - one-cycle pulse on a 1->0 transition of sync_o[0]
module spi_sync_edge #(
   parameter int unsigned             STAGES  = 2,
   parameter int unsigned             WIDTH   = 1,
   parameter logic [WIDTH-1:0]        RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] sync_o,
   output logic             rise_o,
   output logic             fall_o
);

   logic [WIDTH-1:0] chain_q [STAGES];
   logic             prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            chain_q[i] <= RST_VAL;
         end
         prev_q <= RST_VAL[0];
      end else begin
         chain_q[0] <= d_i;
         for (int unsigned i = 1; i < STAGES; i++) begin
            chain_q[i] <= chain_q[i-1];
         end
         prev_q <= chain_q[STAGES-1][0];
      end
   end

   assign sync_o = chain_q[STAGES-1];
   assign rise_o = sync_o[0] & ~prev_q;
   assign fall_o = ~sync_o[0] & prev_q;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 target giving an SPI master access to a bank of 8-bit
// registers. All SPI pins are oversampled in clk (SCLK <= clk/8).
// Frame: byte0 = {rnw, addr[6:0]}, then data bytes; address increments per
// data byte with 7-bit wrap.
// Ports:
//   clk, reset_n          - system clock, asynchronous active-low reset
//   spi_sclk/mosi/ss_n    - SPI inputs from the master
//   spi_miso, spi_miso_oe - SPI output data and its drive enable
//   reg_q                 - register contents, reg n at [8n+7:8n]
//   wr_strobe/addr/data   - one-cycle notification of each committed write
module spi_slave_regfile
   import spi_slave_pkg::*;
#(
   parameter int unsigned NUM_REGS    = 16,
   parameter logic [7:0]  RESET_VAL   = 8'h00,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  spi_sclk,
   input  logic                  spi_mosi,
   input  logic                  spi_ss_n,
   output logic                  spi_miso,
   output logic                  spi_miso_oe,
   output logic [NUM_REGS*8-1:0] reg_q,
   output logic                  wr_strobe,
   output logic [6:0]            wr_addr,
   output logic [7:0]            wr_data
);

   logic [2:0] sync;
   logic       sclk_rise, sclk_fall;
   logic       mosi_s, ss_active;

   // ss_n resets to 1 so the target comes out of reset deselected.
   spi_sync_edge #(
      .STAGES  (SYNC_STAGES),
      .WIDTH   (3),
      .RST_VAL (3'b100)
   ) u_sync (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .d_i    ({spi_ss_n, spi_mosi, spi_sclk}),
      .sync_o (sync),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall)
   );

   assign mosi_s    = sync[1];
   assign ss_active = ~sync[2];

   state_e              state_q, state_d;
   logic [2:0]          bit_cnt_q, bit_cnt_d;
   logic [BYTE_W-1:0]   rx_q, rx_d, rx_next;
   logic [BYTE_W-1:0]   tx_q, tx_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                rnw_q, rnw_d;
   logic                miso_q, miso_d;
   logic                wr_en;
   logic                wr_strobe_q;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [BYTE_W-1:0]   wr_data_q, wr_data_d;
   logic [ADDR_W-1:0]   rd_addr;
   logic [BYTE_W-1:0]   rd_data;
   logic [BYTE_W-1:0]   regs_q [NUM_REGS];

   assign rx_next = {rx_q[BYTE_W-2:0], mosi_s};

   // One read port serves both the command-byte load and the per-byte
   // reload during read bursts; out-of-range addresses read as zero.
   assign rd_addr = (state_q == CMD) ? rx_next[ADDR_W-1:0] : addr_q + 7'd1;

   always_comb begin
      rd_data = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (rd_addr == ADDR_W'(i)) rd_data = regs_q[i];
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      addr_d    = addr_q;
      rnw_d     = rnw_q;
      miso_d    = miso_q;
      wr_en     = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      // Deselect overrides any SCLK edge seen in the same cycle.
      if (!ss_active) begin
         state_d = IDLE;
         miso_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d   = CMD;
               bit_cnt_d = '0;
               rx_d      = '0;
               tx_d      = '0;
               miso_d    = 1'b0;
            end
            CMD: begin
               if (sclk_rise) begin
                  rx_d      = rx_next;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     rnw_d   = rx_next[RNW_BIT];
                     addr_d  = rx_next[ADDR_W-1:0];
                     tx_d    = rx_next[RNW_BIT] ? rd_data : '0;
                     state_d = DATA;
                  end
               end
            end
            DATA: begin
               if (sclk_rise) begin
                  rx_d      = rx_next;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     addr_d = addr_q + 7'd1;
                     if (rnw_q) begin
                        tx_d = rd_data;
                     end else if (32'(addr_q) < NUM_REGS) begin
                        wr_en     = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = rx_next;
                     end
                  end
               end else if (sclk_fall) begin
                  miso_d = tx_q[BYTE_W-1];
                  tx_d   = {tx_q[BYTE_W-2:0], 1'b0};
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         addr_q      <= '0;
         rnw_q       <= 1'b0;
         miso_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= RESET_VAL;
         end
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         addr_q      <= addr_d;
         rnw_q       <= rnw_d;
         miso_q      <= miso_d;
         wr_strobe_q <= wr_en;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         // Register update lands on the same edge that raises wr_strobe.
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wr_en && wr_addr_d == ADDR_W'(i)) regs_q[i] <= wr_data_d;
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign reg_q[8*g +: 8] = regs_q[g];
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = ss_active;
   assign wr_strobe   = wr_strobe_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: two instances (16 and 128 registers) share
// reset, SCLK and MOSI; each has its own select. Frames are driven as an
// SPI mode-0 master and compared against an array-based register model.
module tb_spi_slave_regfile;

   logic clk = 1'b0;
   logic reset_n, sclk, mosi, ss16, ss128;
   logic miso16, oe16, ws16, miso128, oe128, ws128;
   logic [127:0]  rq16;
   logic [1023:0] rq128;
   logic [6:0]    wa16, wa128;
   logic [7:0]    wd16, wd128;

   always #5 clk = ~clk;

   spi_slave_regfile #(.NUM_REGS(16), .RESET_VAL(8'h00), .SYNC_STAGES(2)) u_dut16 (
      .clk(clk), .reset_n(reset_n), .spi_sclk(sclk), .spi_mosi(mosi), .spi_ss_n(ss16),
      .spi_miso(miso16), .spi_miso_oe(oe16), .reg_q(rq16),
      .wr_strobe(ws16), .wr_addr(wa16), .wr_data(wd16));

   spi_slave_regfile #(.NUM_REGS(128), .RESET_VAL(8'h00), .SYNC_STAGES(2)) u_dut128 (
      .clk(clk), .reset_n(reset_n), .spi_sclk(sclk), .spi_mosi(mosi), .spi_ss_n(ss128),
      .spi_miso(miso128), .spi_miso_oe(oe128), .reg_q(rq128),
      .wr_strobe(ws128), .wr_addr(wa128), .wr_data(wd128));

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   task automatic check_eq(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain register arrays plus observed strobe logs.
   logic [7:0]  m16 [16];
   logic [7:0]  m128[128];
   logic [14:0] sq16[$];
   logic [14:0] sq128[$];
   logic [1023:0] prev16, prev128;
   logic          prev_rst = 1'b0;

   always @(negedge clk) begin
      if (ws16)  sq16.push_back({wa16, wd16});
      if (ws128) sq128.push_back({wa128, wd128});
      if (reset_n && prev_rst) begin
         if (1024'(rq16) !== prev16) check_eq("regq16_only_on_strobe", 1024'(ws16), 1024'(1));
         if (rq128 !== prev128)      check_eq("regq128_only_on_strobe", 1024'(ws128), 1024'(1));
      end
      prev16   = 1024'(rq16);
      prev128  = rq128;
      prev_rst = reset_n;
   end

   function automatic logic [1023:0] mvec(input int sel);
      logic [1023:0] v = '0;
      if (sel == 1) for (int i = 0; i < 128; i++) v[8*i +: 8] = m128[i];
      else          for (int i = 0; i < 16; i++)  v[8*i +: 8] = m16[i];
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 128; i++) m128[i] = 8'h00;
      for (int i = 0; i < 16; i++)  m16[i]  = 8'h00;
   endtask

   logic [7:0] txb[16];
   logic [7:0] rxb[16];
   int hp = 4;
   int cur_sel = 0;

   // One SPI bit: MOSI set on the falling phase, MISO sampled just before
   // the rising edge (the master's sampling point).
   task automatic spi_bit(input logic b, output logic m);
      mosi = b;
      repeat (hp) @(negedge clk);
      m = (cur_sel == 1) ? miso128 : miso16;
      sclk = 1'b1;
      repeat (hp) @(negedge clk);
      sclk = 1'b0;
   endtask

   // nbytes full bytes from txb (byte0 = command), then tail_bits of txb[nbytes].
   task automatic frame(input int sel, input int nbytes, input int tail_bits);
      logic m;
      logic rnw;
      int a0, a, nregs;
      logic [14:0] eq[$];
      cur_sel = sel;
      nregs = (sel == 1) ? 128 : 16;
      @(negedge clk);
      if (sel == 1) ss128 = 1'b0; else ss16 = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("oe_selected", 1024'((sel == 1) ? oe128 : oe16), 1024'(1));
      for (int i = 0; i < nbytes; i++)
         for (int b = 7; b >= 0; b--) begin
            spi_bit(txb[i][b], m);
            rxb[i][b] = m;
         end
      for (int b = 0; b < tail_bits; b++) spi_bit(txb[nbytes][7-b], m);
      repeat (hp) @(negedge clk);
      if (sel == 1) ss128 = 1'b1; else ss16 = 1'b1;
      repeat (6) @(negedge clk);
      check_eq("oe_deselected", 1024'((sel == 1) ? oe128 : oe16), 1024'(0));

      if (nbytes >= 1) begin
         rnw = txb[0][7];
         a0  = int'(txb[0][6:0]);
         check_eq("miso_cmd_byte", 1024'(rxb[0]), 1024'(0));
         for (int i = 1; i < nbytes; i++) begin
            a = (a0 + i - 1) % 128;
            if (rnw) begin
               check_eq("read_byte", 1024'(rxb[i]),
                        1024'((a < nregs) ? ((sel == 1) ? m128[a] : m16[a]) : 8'h00));
            end else begin
               check_eq("miso_write_frame", 1024'(rxb[i]), 1024'(0));
               if (a < nregs) begin
                  if (sel == 1) m128[a] = txb[i]; else m16[a] = txb[i];
                  eq.push_back({7'(a), txb[i]});
               end
            end
         end
      end
      if (sel == 1) begin
         check_eq("strobe_count", 1024'(sq128.size()), 1024'(eq.size()));
         for (int k = 0; k < eq.size() && k < sq128.size(); k++)
            check_eq("strobe_addr_data", 1024'(sq128[k]), 1024'(eq[k]));
         check_eq("regq128_model", rq128, mvec(1));
         check_eq("regq16_untouched", 1024'(rq16), mvec(0));
      end else begin
         check_eq("strobe_count", 1024'(sq16.size()), 1024'(eq.size()));
         for (int k = 0; k < eq.size() && k < sq16.size(); k++)
            check_eq("strobe_addr_data", 1024'(sq16[k]), 1024'(eq[k]));
         check_eq("regq16_model", 1024'(rq16), mvec(0));
         check_eq("regq128_untouched", rq128, mvec(1));
      end
      sq16.delete();
      sq128.delete();
   endtask

   initial begin
      logic m;
      reset_n = 1'b0; sclk = 1'b0; mosi = 1'b0; ss16 = 1'b1; ss128 = 1'b1;
      model_clear();
      repeat (5) @(negedge clk);
      check_eq("rst_regq16", 1024'(rq16), '0);
      check_eq("rst_regq128", rq128, '0);
      check_eq("rst_oe", 1024'({oe16, oe128}), '0);
      check_eq("rst_miso", 1024'({miso16, miso128}), '0);
      check_eq("rst_wr_if", 1024'({ws16, wa16, wd16, ws128, wa128, wd128}), '0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      // Single write at clk/8.
      hp = 4;
      txb[0] = 8'h05; txb[1] = 8'hA5;
      frame(0, 2, 0);
      check_eq("write_reg5", 1024'(rq16[47:40]), 1024'(8'hA5));

      // Burst write 3,4 then burst read back.
      hp = 5;
      txb[0] = 8'h03; txb[1] = 8'h11; txb[2] = 8'h22;
      frame(0, 3, 0);
      txb[0] = 8'h83; txb[1] = 8'h00; txb[2] = 8'h00;
      frame(0, 3, 0);
      check_eq("burst_rd0", 1024'(rxb[1]), 1024'(8'h11));
      check_eq("burst_rd1", 1024'(rxb[2]), 1024'(8'h22));

      // Out-of-range write is dropped; out-of-range read returns zero.
      txb[0] = 8'h20; txb[1] = 8'h55;
      frame(0, 2, 0);
      txb[0] = 8'hA0; txb[1] = 8'hFF;
      frame(0, 2, 0);
      check_eq("oor_read", 1024'(rxb[1]), 1024'(0));

      // Abort after 5 bits of the data byte, then a clean write.
      txb[0] = 8'h02; txb[1] = 8'h77;
      frame(0, 1, 5);
      check_eq("abort_reg2", 1024'(rq16[23:16]), 1024'(8'h00));
      txb[0] = 8'h02; txb[1] = 8'h3C;
      frame(0, 2, 0);
      check_eq("after_abort_reg2", 1024'(rq16[23:16]), 1024'(8'h3C));

      // Address wrap 127 -> 0 on the 128-register instance.
      txb[0] = 8'h7F; txb[1] = 8'h01; txb[2] = 8'h02;
      frame(1, 3, 0);
      check_eq("wrap_reg127", 1024'(rq128[1023:1016]), 1024'(8'h01));
      check_eq("wrap_reg0", 1024'(rq128[7:0]), 1024'(8'h02));

      // Randomized frames.
      for (int f = 0; f < 40; f++) begin
         int sel, nb, tail;
         logic rnw;
         logic [6:0] addr;
         sel  = int'($urandom % 2);
         hp   = int'($urandom_range(4, 8));
         rnw  = 1'($urandom % 2);
         addr = ($urandom % 3 == 0) ? 7'($urandom) :
                ((sel == 1) ? 7'($urandom_range(120, 127)) : 7'($urandom_range(0, 19)));
         nb   = int'($urandom_range(1, 5));
         tail = ($urandom % 4 == 0) ? int'($urandom_range(1, 7)) : 0;
         txb[0] = {rnw, addr};
         for (int i = 1; i <= nb + 1; i++) txb[i] = 8'($urandom);
         frame(sel, nb + 1, tail);
      end

      // Reset asserted in the middle of a byte.
      hp = 4;
      cur_sel = 1;
      @(negedge clk);
      ss128 = 1'b0;
      repeat (4) @(negedge clk);
      spi_bit(1'b0, m); spi_bit(1'b0, m); spi_bit(1'b1, m);
      reset_n = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      check_eq("midrst_regq128", rq128, '0);
      check_eq("midrst_regq16", 1024'(rq16), '0);
      check_eq("midrst_oe", 1024'(oe128), '0);
      check_eq("midrst_miso", 1024'(miso128), '0);
      ss128 = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("midrst_no_strobe", 1024'(sq128.size() + sq16.size()), '0);
      txb[0] = 8'h10; txb[1] = 8'h5A;
      frame(1, 2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
